// File: rtl/image_pkg.sv
// Shared types and timing helpers for the image timing generator.
package image_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int unsigned h_total(input int unsigned sync_w, input int unsigned bp,
                                            input int unsigned act, input int unsigned fp);
        return sync_w + bp + act + fp;
    endfunction

    function automatic int unsigned v_total(input int unsigned sync_l, input int unsigned bp_l,
                                            input int unsigned act, input int unsigned fp_l);
        return sync_l + bp_l + act + fp_l;
    endfunction

    // First active position on an axis: after the sync pulse and back porch.
    function automatic int unsigned act_start(input int unsigned sync_w, input int unsigned bp);
        return sync_w + bp;
    endfunction

    // One past the last active position on an axis.
    function automatic int unsigned act_end(input int unsigned sync_w, input int unsigned bp,
                                            input int unsigned act);
        return sync_w + bp + act;
    endfunction

endpackage

// File: rtl/image_timing_gen_timing_counter.sv
// Horizontal/vertical raster counter pair; counts only while en is high.
module timing_counter #(
    parameter int unsigned H_TOTAL = 688,
    parameter int unsigned V_TOTAL = 486,
    parameter int unsigned HW      = 12,
    parameter int unsigned VW      = 12
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          en,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          line_end_c,
    output logic          v_last_c
);

    assign line_end_c = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last_c   = (v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (line_end_c) begin
                h_cnt <= '0;
                v_cnt <= v_last_c ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

endmodule

// File: rtl/image_timing_gen.sv
// Raster video timing transmitter with valid/ready pixel intake.
// Optional test-pattern ramp generator enabled by IMAGE_TIMING_GEN_PATTERN_EN.
module image_timing_gen
    import image_pkg::*;
#(
    parameter int unsigned IW      = 640,
    parameter int unsigned IH      = 480,
    parameter int unsigned DW      = 8,
    parameter int unsigned HSYNC_W = 16,
    parameter int unsigned HBP     = 16,
    parameter int unsigned HFP     = 16,
    parameter int unsigned VSYNC_L = 2,
    parameter int unsigned VBP_L   = 2,
    parameter int unsigned VFP_L   = 2,
    parameter int unsigned IW_DW   = 12,
    parameter int unsigned IH_DW   = 12
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          enable,
    input  logic [DW-1:0] pix_data,
    input  logic          pix_valid,
`ifdef IMAGE_TIMING_GEN_PATTERN_EN
    input  logic          test_mode,
`endif
    output logic          pix_ready,
    output logic          vsync,
    output logic          hsync,
    output logic          dvalid,
    output logic [DW-1:0] dout,
    output logic          frame_start,
    output logic          underflow
);

    localparam int unsigned HTOTAL  = h_total(HSYNC_W, HBP, IW, HFP);
    localparam int unsigned VTOTAL  = v_total(VSYNC_L, VBP_L, IH, VFP_L);
    localparam int unsigned H_ACT_S = act_start(HSYNC_W, HBP);
    localparam int unsigned H_ACT_E = act_end(HSYNC_W, HBP, IW);
    localparam int unsigned V_ACT_S = act_start(VSYNC_L, VBP_L);
    localparam int unsigned V_ACT_E = act_end(VSYNC_L, VBP_L, IH);

    state_t             state;
    state_t             next_state;
    logic [IW_DW-1:0]   h_cnt;
    logic [IH_DW-1:0]   v_cnt;
    logic               line_end_c;
    logic               v_last_c;
    logic               frame_end_c;
    logic               run;
    logic               vsync_c;
    logic               hsync_c;
    logic               active_c;
    logic               frame_bound_c;
    logic [DW-1:0]      pix_c;

    assign run         = (state == RUN);
    assign frame_end_c = run && line_end_c && v_last_c;

    timing_counter #(
        .H_TOTAL (HTOTAL),
        .V_TOTAL (VTOTAL),
        .HW      (IW_DW),
        .VW      (IH_DW)
    ) u_timing_counter (
        .clk        (clk),
        .arst       (arst),
        .en         (run),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .line_end_c (line_end_c),
        .v_last_c   (v_last_c)
    );

    // Raster decode from the current counters.
    assign vsync_c  = run && (v_cnt < IH_DW'(VSYNC_L));
    assign hsync_c  = run && (h_cnt < IW_DW'(HSYNC_W));
    assign active_c = run
                   && (v_cnt >= IH_DW'(V_ACT_S)) && (v_cnt < IH_DW'(V_ACT_E))
                   && (h_cnt >= IW_DW'(H_ACT_S)) && (h_cnt < IW_DW'(H_ACT_E));

    // A new frame begins on the next clock: leaving IDLE or wrapping while still enabled.
    assign frame_bound_c = enable && (!run || frame_end_c);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable) next_state = RUN;
            RUN:     if (frame_end_c && !enable) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

`ifdef IMAGE_TIMING_GEN_PATTERN_EN
    logic               tm_q;
    logic [DW-1:0]      frame_cnt;
    logic [IW_DW-1:0]   col_c;

    assign col_c     = h_cnt - IW_DW'(H_ACT_S);
    assign pix_ready = active_c && !tm_q;
    assign pix_c     = tm_q ? (DW'(col_c) + frame_cnt) : (pix_valid ? pix_data : '0);

    // Test mode is latched per frame; the ramp offset advances once per completed frame.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tm_q      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (frame_bound_c) tm_q <= test_mode;
            if (frame_end_c)   frame_cnt <= frame_cnt + DW'(1);
        end
    end
`else
    assign pix_ready = active_c;
    assign pix_c     = pix_valid ? pix_data : '0;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= IDLE;
            vsync       <= 1'b0;
            hsync       <= 1'b0;
            dvalid      <= 1'b0;
            dout        <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            state       <= next_state;
            vsync       <= vsync_c;
            hsync       <= hsync_c;
            dvalid      <= active_c;
            frame_start <= run && (h_cnt == '0) && (v_cnt == '0);
            if (!run) begin
                dout <= '0;
            end else if (active_c) begin
                dout <= pix_c;
            end
            if (pix_ready && !pix_valid) underflow <= 1'b1;
        end
    end

endmodule
